dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, data width of both requester ports and the memory port.
REQ-002 Parameter: ADDR_W, 9, word address width of the data memory.
REQ-003 Parameter: MAX_BURST, 4, maximum consecutive grants to one owner while the other requester waits; legal range 1..15.
REQ-004 Ports (name direction width meaning):
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset.
- req0 / req1  input  1  access request from M0 (core LSU) / M1 (aux loader/debug).
- we0 / we1  input  1  1 = write, 0 = read.
- addr0 / addr1  input  ADDR_W  word address.
- wdata0 / wdata1  input  DATA_W  write data.
- gnt0 / gnt1  output  1  access issued to memory this cycle.
- rvalid0 / rvalid1  output  1  read data valid for that requester.
- rdata0 / rdata1  output  DATA_W  read data.
- mem_wr  output  1  memory write strobe.
- mem_rd  output  1  memory read strobe.
- mem_addr  output  ADDR_W  memory address.
- mem_wr_data  output  DATA_W  memory write data.
- mem_rd_data  input  DATA_W  memory read data, valid 1 cycle after mem_rd.

Function
REQ-005 Requester SHALL hold req, we, addr, wdata stable until it sees gnt in the same cycle; arbiter never drops a held request.
REQ-006 At most one of gnt0/gnt1 SHALL be high per cycle; gnt is combinational from req and registered state.
REQ-007 Granted access SHALL drive mem_addr/mem_wr_data from that requester in the grant cycle, with mem_wr = we and mem_rd = !we.
REQ-008 With no grant, mem_wr = mem_rd = 0; mem_addr and mem_wr_data = 0.
REQ-009 Granted read SHALL produce rvalidN = 1 for exactly one cycle, the cycle after grant, with rdataN = mem_rd_data; rdata of the non-reading port = 0.
REQ-010 Writes SHALL complete in the grant cycle; no rvalid.
REQ-011 FSM states: IDLE, OWN0, OWN1; state after a cycle = OWNx if Mx granted, else IDLE.
REQ-012 Burst counter cnt (4 bits): set to 1 when owner changes or on grant from IDLE; incremented, saturating at MAX_BURST, on repeat grant to same owner.
REQ-013 In OWNx: grant Mx if reqx and not (other req and cnt == MAX_BURST); otherwise grant other requester if requesting.
REQ-014 In IDLE, both requesting: grant the requester not granted last (last_gnt register); single requester: grant it.
REQ-015 last_gnt SHALL update on every grant.
REQ-016 Back-to-back grants SHALL be allowed every cycle; a read followed by any access in the next cycle is legal (rvalid and new grant coincide).
REQ-017 Owner dropping req SHALL hand over to the other requester in the same cycle with no bubble.

Reset
REQ-018 While reset = 0 at a rising edge: state = IDLE, cnt = 0, last_gnt = M1 (so M0 wins first tie), pending read flags cleared.
REQ-019 While reset = 0 all outputs SHALL be 0 (gnt, rvalid, rdata, mem_*), regardless of req.
REQ-020 A read granted in the cycle before reset asserts SHALL NOT produce rvalid.

Configuration
REQ-021 Macro DMEM_ARB_STATS_EN defined: add output conflict_cnt (16 bits), incremented each cycle both req are high (one denied), saturating at 0xFFFF, reset to 0.
REQ-022 Macro undefined: port conflict_cnt and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-023 After reset, req0=1 read addr 0x010, mem returns 0xDEADBEEF -> gnt0 cycle 0, mem_rd=1, mem_addr=0x010; rvalid0=1, rdata0=0xDEADBEEF cycle 1.
REQ-024 req0 and req1 first asserted together from IDLE after reset -> gnt0 first; next cycle in IDLE tie -> M1 wins.
REQ-025 req0 and req1 held high continuously, MAX_BURST=4 -> grant pattern 0,0,0,0,1,1,1,1,0... ; conflict_cnt (STATS_EN) increments every cycle.
REQ-026 M1 write 0x1FF, data 0x12345678, concurrent M0 read granted previous cycle -> mem_wr=1, mem_addr=0x1FF, mem_wr_data=0x12345678 while rvalid0=1 same cycle.
REQ-027 reset driven low the cycle after a granted M0 read -> rvalid0 = 0, all outputs 0, next post-reset tie grants M0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master data-memory arbiter with burst-limited ownership.
// Defining DMEM_ARB_STATS_EN adds a saturating conflict_cnt output.
module dmem_arbiter #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 9,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              mem_wr,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wr_data,
   input  logic [DATA_W-1:0] mem_rd_data
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [15:0]       conflict_cnt
`endif
);
   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] OWN0 = 2'b01;
   localparam logic [1:0] OWN1 = 2'b10;
   localparam logic [3:0] MAX  = 4'(MAX_BURST);
   logic [1:0] state;
   logic [3:0] cnt;
   logic       last_gnt, pend0, pend1, cap;
   assign cap = cnt == MAX;
   // M0 wins a tie when it owns and is under the cap, when M1 owns and hit the cap, or from IDLE when M1 went last
   assign gnt0 = reset & req0 & (!req1 | (state == OWN0 ? !cap : state == OWN1 ? cap : last_gnt));
   assign gnt1 = reset & req1 & !gnt0;
   assign mem_wr      = (gnt0 & we0) | (gnt1 & we1);
   assign mem_rd      = (gnt0 & !we0) | (gnt1 & !we1);
   assign mem_addr    = gnt0 ? addr0 : gnt1 ? addr1 : '0;
   assign mem_wr_data = gnt0 ? wdata0 : gnt1 ? wdata1 : '0;
   assign rvalid0     = reset & pend0;
   assign rvalid1     = reset & pend1;
   assign rdata0      = rvalid0 ? mem_rd_data : '0;
   assign rdata1      = rvalid1 ? mem_rd_data : '0;
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         last_gnt <= 1'b1;
         pend0    <= 1'b0;
         pend1    <= 1'b0;
      end else begin
         state <= gnt0 ? OWN0 : gnt1 ? OWN1 : IDLE;
         pend0 <= gnt0 & !we0;
         pend1 <= gnt1 & !we1;
         if (gnt0 | gnt1) begin
            last_gnt <= gnt1;
            cnt      <= (state == (gnt0 ? OWN0 : OWN1)) ? (cap ? cnt : cnt + 4'd1) : 4'd1;
         end
      end
   end
`ifdef DMEM_ARB_STATS_EN
   logic [15:0] conflicts;
   assign conflict_cnt = reset ? conflicts : '0;
   always_ff @(posedge clk) begin
      if (!reset)
         conflicts <= '0;
      else if (req0 && req1 && conflicts != 16'hFFFF)
         conflicts <= conflicts + 16'd1;
   end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios then random traffic, checked against an
// ownership/run-length model of the arbitration rules.
module tb_dmem_arbiter;
   localparam int MB = 4;
   logic        clk = 0, reset = 0, req0 = 0, req1 = 0, we0 = 0, we1 = 0;
   logic [8:0]  addr0 = 0, addr1 = 0, mem_addr;
   logic [31:0] wdata0 = 0, wdata1 = 0, mem_rd_data = 0, rdata0, rdata1, mem_wr_data;
   logic        gnt0, gnt1, rvalid0, rvalid1, mem_wr, mem_rd;
   int checks = 0, errors = 0;
   int m_owner = -1, m_run = 0, m_last = 1, m_pend = -1;
   bit p0 = 0, p1 = 0;
   bit pat [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};

   dmem_arbiter dut (
      .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1), .mem_wr(mem_wr), .mem_rd(mem_rd),
      .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic m0(input logic r, input logic w, input logic [8:0] a, input logic [31:0] d);
      req0 = r; we0 = w; addr0 = a; wdata0 = d;
   endtask

   task automatic m1(input logic r, input logic w, input logic [8:0] a, input logic [31:0] d);
      req1 = r; we1 = w; addr1 = a; wdata1 = d;
   endtask

   // Checks this cycle's outputs against the model, then advances the model past the coming edge
   task automatic chk_cycle(output int w);
      logic wwe;
      #2;
      if (!reset) w = -1;
      else if (req0 && req1)
         w = (m_owner < 0) ? (m_last == 0 ? 1 : 0) : (m_run == MB ? 1 - m_owner : m_owner);
      else w = req0 ? 0 : req1 ? 1 : -1;
      wwe = (w == 0) ? we0 : we1;
      chk("gnt0", gnt0, w == 0);
      chk("gnt1", gnt1, w == 1);
      chk("mem_wr", mem_wr, w >= 0 && wwe);
      chk("mem_rd", mem_rd, w >= 0 && !wwe);
      chk("mem_addr", mem_addr, w == 0 ? addr0 : w == 1 ? addr1 : 9'd0);
      chk("mem_wr_data", mem_wr_data, w == 0 ? wdata0 : w == 1 ? wdata1 : 32'd0);
      chk("rvalid0", rvalid0, reset && m_pend == 0);
      chk("rvalid1", rvalid1, reset && m_pend == 1);
      chk("rdata0", rdata0, (reset && m_pend == 0) ? mem_rd_data : 32'd0);
      chk("rdata1", rdata1, (reset && m_pend == 1) ? mem_rd_data : 32'd0);
      if (!reset) begin
         m_owner = -1; m_run = 0; m_last = 1; m_pend = -1;
      end else begin
         m_pend = (w >= 0 && !wwe) ? w : -1;
         if (w >= 0) begin
            m_run = (w == m_owner) ? (m_run < MB ? m_run + 1 : m_run) : 1;
            m_last = w;
         end
         m_owner = w;
      end
   endtask

   task automatic adv();
      @(negedge clk);
   endtask

   task automatic step();
      int w;
      chk_cycle(w);
      adv();
   endtask

   initial begin
      int w;
      logic [31:0] d;
      @(negedge clk);
      reset = 0; m0(1, 0, 9'h5, 0); m1(1, 1, 9'h6, 1);
      chk_cycle(w); chk("rst_gnt0", gnt0, 0); chk("rst_mem_rd", mem_rd, 0); adv();
      step();
      // Tie from IDLE after reset goes to M0, the next IDLE tie to M1
      reset = 1;
      chk_cycle(w); chk("tie_first_gnt0", gnt0, 1); chk("tie_first_gnt1", gnt1, 0); adv();
      m0(0, 0, 0, 0); m1(0, 0, 0, 0); step();
      m0(1, 1, 9'h7, 32'h77); m1(1, 1, 9'h8, 32'h88);
      chk_cycle(w); chk("tie_second_gnt1", gnt1, 1); adv();
      m0(0, 0, 0, 0); m1(0, 0, 0, 0); step();
      // Single M0 read returning 0xDEADBEEF
      m0(1, 0, 9'h010, 0);
      chk_cycle(w); chk("rd_gnt0", gnt0, 1); chk("rd_mem_rd", mem_rd, 1); chk("rd_addr", mem_addr, 9'h010); adv();
      m0(0, 0, 0, 0); mem_rd_data = 32'hDEADBEEF;
      chk_cycle(w); chk("rd_rvalid0", rvalid0, 1); chk("rd_rdata0", rdata0, 32'hDEADBEEF); adv();
      m1(1, 1, 9'h3, 32'h3); step();
      m1(0, 0, 0, 0); step();
      // Continuous contention alternates in bursts of MAX_BURST
      m0(1, 0, 9'h11, 0); m1(1, 0, 9'h22, 0);
      for (int i = 0; i < 9; i++) begin
         mem_rd_data = $urandom;
         chk_cycle(w); chk("burst_gnt1", gnt1, pat[i]); chk("burst_gnt0", gnt0, !pat[i]); adv();
      end
      m0(0, 0, 0, 0); m1(0, 0, 0, 0); step();
      // M1 write coinciding with rvalid of the previous M0 read
      m0(1, 0, 9'h020, 0); step();
      m0(0, 0, 0, 0); m1(1, 1, 9'h1FF, 32'h12345678); mem_rd_data = 32'hCAFEF00D;
      chk_cycle(w);
      chk("b2b_mem_wr", mem_wr, 1); chk("b2b_addr", mem_addr, 9'h1FF);
      chk("b2b_wdata", mem_wr_data, 32'h12345678); chk("b2b_rvalid0", rvalid0, 1);
      chk("b2b_rdata0", rdata0, 32'hCAFEF00D);
      adv();
      m1(0, 0, 0, 0); step();
      // Reset right after a granted read suppresses its rvalid
      m0(1, 0, 9'h033, 0);
      chk_cycle(w); chk("prerst_gnt0", gnt0, 1); adv();
      reset = 0; m1(1, 0, 9'h044, 0);
      chk_cycle(w); chk("inrst_rvalid0", rvalid0, 0); chk("inrst_gnt0", gnt0, 0); adv();
      reset = 1;
      chk_cycle(w); chk("postrst_gnt0", gnt0, 1); adv();
      m0(0, 0, 0, 0); m1(0, 0, 0, 0); step();
      // Random traffic; requesters hold until the model says they were granted
      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom % 64) != 0;
         mem_rd_data = $urandom;
         if (!p0) begin
            p0 = ($urandom % 3) != 0; d = $urandom;
            m0(p0, d[0], d[9:1], $urandom);
         end
         if (!p1) begin
            p1 = ($urandom % 3) != 0; d = $urandom;
            m1(p1, d[0], d[9:1], $urandom);
         end
         chk_cycle(w);
         if (w == 0) p0 = 0;
         if (w == 1) p1 = 0;
         adv();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
